// File: rtl/timer_capture.sv
// timer_capture: bus-mapped input-capture unit. It measures the period or the
// pulse width of cap_i in clk cycles, latches the result and raises an IRQ.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   data_i      : bus write data
//   addr_i      : bus address, only [3:0] decoded
//   we_i        : bus write strobe
//   cap_i       : asynchronous capture pin
//   data_o      : combinational read data for addr_i
//   int_sig_o   : interrupt (pending & int_en)
//
// Register map:
//   0x0 CTRL    [0] en [1] int_en [2] pending(W1C) [3] ovf(W1C)
//               [4] edge (1 = falling) [5] mode (1 = pulse width)
//   0x4 COUNT   running count, read-only
//   0x8 CAPTURE latched result, read-only
//   0xC TIMEOUT 0 disables the timeout
module timer_capture #(
    parameter int CPU_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CPU_WIDTH-1:0] data_i,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic                 cap_i,
    output logic [CPU_WIDTH-1:0] data_o,
    output logic                 int_sig_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    localparam logic [CPU_WIDTH-1:0] ONE = CPU_WIDTH'(1);

    state_e state_q, state_d;

    logic en_q, en_d;
    logic int_en_q, int_en_d;
    logic pend_q, pend_d;
    logic ovf_q, ovf_d;
    logic edge_q, edge_d;
    logic mode_q, mode_d;

    // Copies of edge/mode taken when the FSM arms.
    logic edge_l_q, edge_l_d;
    logic mode_l_q, mode_l_d;

    logic [CPU_WIDTH-1:0] count_q, count_d;
    logic [CPU_WIDTH-1:0] capture_q, capture_d;
    logic [CPU_WIDTH-1:0] timeout_q, timeout_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    logic sync_s;
    logic rise, fall;
    logic start_ev, stop_ev;
    logic wr_ctrl, wr_to;
    logic abort_req;
    logic tmo_hit;
    logic done, tmo;
    logic [CPU_WIDTH-1:0] count_inc;
    logic [CPU_WIDTH-1:0] ctrl_rd;
    logic addr_unused;

    assign addr_unused = ^addr_i[31:4];

    // ---------------------------------------------------------------
    // Pin conditioning: synchronizer chain followed by a history flop
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cap_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~hist_q;
    assign fall   = ~sync_s & hist_q;

    assign start_ev = edge_l_q ? fall : rise;
    // Period mode stops on the start edge, width mode on the opposite one,
    // so the stop edge is falling exactly when edge and mode differ.
    assign stop_ev  = (edge_l_q ^ mode_l_q) ? fall : rise;

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    assign wr_ctrl = we_i && (addr_i[3:0] == 4'h0);
    assign wr_to   = we_i && (addr_i[3:0] == 4'hC);

    // Software disable: explicit en=0 write, or en already low.
    assign abort_req = (wr_ctrl && !data_i[0]) || !en_q;

    assign count_inc = count_q + ONE;
    assign tmo_hit   = (timeout_q != '0) && (count_inc >= timeout_q);

    // ---------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        edge_l_d = edge_l_q;
        mode_l_d = mode_l_q;
        done     = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d  = ST_ARM;
                    edge_l_d = edge_q;
                    mode_l_d = mode_q;
                end
            end
            ST_ARM: begin
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (start_ev) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // A stop edge beats a timeout in the same cycle.
                if (stop_ev) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end else if (abort_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Register next state
    // ---------------------------------------------------------------
    always_comb begin
        en_d      = en_q;
        int_en_d  = int_en_q;
        pend_d    = pend_q;
        ovf_d     = ovf_q;
        edge_d    = edge_q;
        mode_d    = mode_q;
        capture_d = capture_q;
        timeout_d = timeout_q;
        count_d   = '0;

        if (wr_ctrl) begin
            en_d     = data_i[0];
            int_en_d = data_i[1];
            edge_d   = data_i[4];
            mode_d   = data_i[5];
            if (data_i[2]) begin
                pend_d = 1'b0;
            end
            if (data_i[3]) begin
                ovf_d = 1'b0;
            end
        end

        // Hardware set wins over a same-cycle W1C; a written en wins
        // over the self-disable.
        if (done || tmo) begin
            pend_d = 1'b1;
            if (!wr_ctrl) begin
                en_d = 1'b0;
            end
        end

        if (done) begin
            capture_d = count_inc;
        end

        if (tmo) begin
            capture_d = '1;
            ovf_d     = 1'b1;
        end

        if (wr_to) begin
            timeout_d = data_i;
        end

        if (state_q == ST_MEASURE && state_d == ST_MEASURE) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            int_en_q  <= 1'b0;
            pend_q    <= 1'b0;
            ovf_q     <= 1'b0;
            edge_q    <= 1'b0;
            mode_q    <= 1'b0;
            edge_l_q  <= 1'b0;
            mode_l_q  <= 1'b0;
            count_q   <= '0;
            capture_q <= '0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            int_en_q  <= int_en_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            edge_q    <= edge_d;
            mode_q    <= mode_d;
            edge_l_q  <= edge_l_d;
            mode_l_q  <= mode_l_d;
            count_q   <= count_d;
            capture_q <= capture_d;
            timeout_q <= timeout_d;
        end
    end

    // ---------------------------------------------------------------
    // Read path and interrupt
    // ---------------------------------------------------------------
    assign ctrl_rd = {{(CPU_WIDTH-6){1'b0}},
                      mode_q, edge_q, ovf_q, pend_q, int_en_q, en_q};

    always_comb begin
        data_o = '0;
        if (rst_n) begin
            case (addr_i[3:0])
                4'h0:    data_o = ctrl_rd;
                4'h4:    data_o = count_q;
                4'h8:    data_o = capture_q;
                4'hC:    data_o = timeout_q;
                default: data_o = '0;
            endcase
        end
    end

    assign int_sig_o = pend_q & int_en_q;

endmodule

// File: doc/timer_capture.md
Name: timer_capture

Overview:
- Memory-mapped input-capture peripheral on the CPU peripheral bus. It is the receiving counterpart of the count-up timer: the timer generates timed events, and this block timestamps an external event.
- Measures, in clk cycles, either the period of an external signal or the width of one pulse. Latches the result, raises a maskable one-shot interrupt, then disables itself.
- Uses the same 32-bit single-cycle register interface as the other peripherals: combinational read, registered write.

Parameters:
- CPU_WIDTH, 32, data/register width.
- SYNC_STAGES, 2, synchronizer flops on cap_i; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- data_i  input  32  write data
- addr_i  input  32  register address; only [3:0] decoded
- we_i  input  1  write strobe, one write per cycle when high
- cap_i  input  1  asynchronous external capture pin
- data_o  output  32  read data, combinational from addr_i
- int_sig_o  output  1  interrupt, high = asserted

Behaviour:
- Register map (offset, addr_i[3:0]):
  - 0x0 CTRL.
    - [0] en.
    - [1] int_en.
    - [2] pending, write-1-clear.
    - [3] ovf, write-1-clear.
    - [4] edge: 0 = rising, 1 = falling.
    - [5] mode: 0 = period, 1 = pulse width.
    - [31:6] read as 0, writes ignored.
  - 0x4 COUNT, read-only running count.
  - 0x8 CAPTURE, read-only latched result.
  - 0xC TIMEOUT, read/write; 0 = no timeout.
- Reset: CTRL, COUNT, CAPTURE and TIMEOUT = 0; synchronizer flops = 0; FSM = IDLE; int_sig_o = 0; data_o = 0 while rst_n = 0.
- int_sig_o = pending & int_en, combinational.
- Read path:
  - data_o is muxed combinationally from addr_i[3:0].
  - Unmapped offsets read 0.
  - Reads have no side effects.
- Input conditioning:
  - cap_i passes through SYNC_STAGES flops, then one history flop.
  - A rise is sync = 1 and hist = 0; a fall is sync = 0 and hist = 1.
  - An edge on cap_i is detected SYNC_STAGES+1 cycles after the pin changes. The latency is identical for both edges, so differences are exact.
- FSM states:
  - IDLE: COUNT held at 0. Go to ARM when en = 1.
  - ARM:
    - Latch edge and mode into internal copies. Bus changes to edge or mode after this point have no effect until the next arm.
    - Wait for the start edge, which is the selected edge.
    - On the start edge: COUNT <= 0, go to MEASURE.
  - MEASURE:
    - COUNT <= COUNT + 1 every cycle.
    - The stop edge is the same edge in period mode and the opposite edge in width mode.
    - On the stop edge: CAPTURE <= COUNT + 1, so an input period of N clk cycles reads N. Then set pending, clear en, go to IDLE.
  - Timeout, checked in MEASURE when TIMEOUT != 0 and COUNT + 1 >= TIMEOUT with no stop edge in that cycle:
    - CAPTURE <= 0xFFFF_FFFF.
    - Set ovf and pending, clear en, go to IDLE.
  - A stop edge in the same cycle as the timeout condition is treated as a normal capture.
  - COUNT wraps from 0xFFFF_FFFF to 0 with no flag when TIMEOUT = 0.
- Abort: a CTRL write with en = 0 while in ARM or MEASURE returns the FSM to IDLE next cycle. COUNT is cleared; CAPTURE, pending and ovf are unchanged.
- CTRL write while enabled with en = 1: no restart; the measurement continues.
- Simultaneous bus write and hardware completion in the same cycle:
  - en, int_en, edge and mode take the written values.
  - pending and ovf are set by hardware even if the write carries 1 (the set wins over the clear).
  - CAPTURE takes the hardware result.
- In IDLE with pending already set, re-arming by writing en = 1 does not clear pending. A new result overwrites CAPTURE.
- TIMEOUT writes take effect on the next cycle's compare, including mid-measurement.

Test Plan:
- Reset with rst_n = 0 for 2 cycles → all four registers read 0, int_sig_o = 0, data_o = 0 during reset.
- Period mode: TIMEOUT = 0, CTRL = 0x03, rising edges every 100 clk on cap_i → CAPTURE = 100, CTRL reads 0x06, int_sig_o = 1. Then write CTRL = 0x04 → int_sig_o = 0, CTRL reads 0x00.
- Width mode, falling edge: CTRL = 0x33, cap_i low for 37 cycles between a fall and a rise → CAPTURE = 37, pending = 1, en = 0.
- Timeout: TIMEOUT = 50, period mode, only one rising edge → 50 cycles after the start edge, CAPTURE = 0xFFFF_FFFF, CTRL reads 0x0E (ovf, pending, int_en set; en cleared).
- Abort: arm, start edge, write CTRL = 0x02 at COUNT = 20 → next cycle COUNT = 0, the FSM is in IDLE, pending = 0, and later edges cause no capture.
- Collision: a W1C write of CTRL = 0x07 in the same cycle as a stop edge → pending reads 1, en reads 1, and the FSM re-arms on the following cycle.
